// File: rtl/all_pkgs.sv
// Shared constants and types for the memory-port arbiter.
package all_pkgs;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned ARB_MAX_IF_WAIT = 4;
  localparam int unsigned ARB_TIMEOUT     = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Single outstanding transaction, DM priority, IF starvation guard, timeout abort.
module mem_port_arbiter
  import all_pkgs::*;
#(
  parameter int unsigned WIDTH       = DATA_WIDTH,
  parameter int unsigned MAX_IF_WAIT = ARB_MAX_IF_WAIT,
  parameter int unsigned TIMEOUT     = ARB_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             if_flush,
  output logic             if_ready,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  input  logic [3:0]       dm_be,
  output logic             dm_ready,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             err
);

  localparam int unsigned WAIT_W = $clog2(MAX_IF_WAIT + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_IF_WAIT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              if_ready_q, if_ready_d;
  logic [WIDTH-1:0]  if_rdata_q, if_rdata_d;
  logic              dm_ready_q, dm_ready_d;
  logic [WIDTH-1:0]  dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] if_wait_cnt_q, if_wait_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              kill_q, kill_d;
  logic              served_if_q, served_if_d;

  logic if_serving;
  logic is_if;
  logic kill_now;
  logic finish;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    if_ready_d    = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_ready_d    = 1'b0;
    dm_rdata_d    = dm_rdata_q;
    err_d         = 1'b0;
    if_wait_cnt_d = if_wait_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    kill_d        = kill_q;
    served_if_d   = served_if_q;
    is_if         = (state_q == BUSY_IF);
    kill_now      = kill_q | (is_if & if_flush);
    finish        = 1'b0;

    // RESP after an IF transaction still counts as IF being served.
    if_serving = is_if || (state_q == RESP && served_if_q);
    if (if_req && !if_serving && if_wait_cnt_q != WAIT_MAX)
      if_wait_cnt_d = if_wait_cnt_q + WAIT_W'(1);

    case (state_q)
      IDLE: begin
        if (if_req && (if_wait_cnt_q == WAIT_MAX || !dm_req)) begin
          state_d       = BUSY_IF;
          mem_req_d     = 1'b1;
          mem_we_d      = 1'b0;
          mem_addr_d    = if_addr;
          mem_wdata_d   = '0;
          mem_be_d      = '1;
          if_wait_cnt_d = '0;
          kill_d        = if_flush;
          served_if_d   = 1'b1;
        end else if (dm_req) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
          served_if_d = 1'b0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (is_if)
          kill_d = kill_now;
        if (mem_ack && mem_req_q) begin
          finish = 1'b1;
          if (is_if)
            if_rdata_d = mem_rdata;
          else
            dm_rdata_d = mem_we_q ? '0 : mem_rdata;
        end else if (tmo_cnt_q == TMO_LAST) begin
          finish = 1'b1;
          err_d  = 1'b1;
          if (is_if)
            if_rdata_d = '0;
          else
            dm_rdata_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (finish) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          if_ready_d = is_if & ~kill_now;
          dm_ready_d = ~is_if;
        end
      end
      RESP: begin
        tmo_cnt_d = '0;
        kill_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      if_ready_q    <= 1'b0;
      if_rdata_q    <= '0;
      dm_ready_q    <= 1'b0;
      dm_rdata_q    <= '0;
      err_q         <= 1'b0;
      if_wait_cnt_q <= '0;
      tmo_cnt_q     <= '0;
      kill_q        <= 1'b0;
      served_if_q   <= 1'b0;
    end else begin
      // Requesters must hold request and payload while their transaction is in flight.
      if (state_q == BUSY_DM)
        assert (dm_req && dm_addr == mem_addr_q && dm_we == mem_we_q);
      if (state_q == BUSY_IF)
        assert (if_req && if_addr == mem_addr_q);
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      if_ready_q    <= if_ready_d;
      if_rdata_q    <= if_rdata_d;
      dm_ready_q    <= dm_ready_d;
      dm_rdata_q    <= dm_rdata_d;
      err_q         <= err_d;
      if_wait_cnt_q <= if_wait_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      kill_q        <= kill_d;
      served_if_q   <= served_if_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected values are hand-computed per cycle.
module tb_mem_port_arbiter;
  import all_pkgs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be, mem_be;
  logic        mem_req, mem_we, mem_ack, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WIDTH(32), .MAX_IF_WAIT(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ack = 0; mem_rdata = '0;
    tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_ready", {if_ready, dm_ready, err}, 0);
    check("rst_state", dut.state_q, IDLE);

    // IF only, ack at cycle 3
    rst = 1'b1; if_req = 1; if_addr = 32'h100;
    tick();
    check("if1_mem_req", mem_req, 1);
    check("if1_mem_addr", mem_addr, 32'h100);
    check("if1_mem_be", mem_be, 4'hF);
    check("if1_mem_we", mem_we, 0);
    tick();
    check("if1_wait_ready", if_ready, 0);
    tick();
    mem_ack = 1; mem_rdata = 32'h00500093;
    tick();
    check("if1_ready", if_ready, 1);
    check("if1_rdata", if_rdata, 32'h00500093);
    check("if1_req_drop", mem_req, 0);
    mem_ack = 0; if_req = 0;
    tick();
    check("if1_ready_pulse", if_ready, 0);

    // Simultaneous: DM store wins, IF afterwards
    if_req = 1; if_addr = 32'h104;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF;
    tick();
    check("sim_mem_we", mem_we, 1);
    check("sim_mem_addr", mem_addr, 32'h200);
    check("sim_mem_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick();
    check("sim_dm_ready", dm_ready, 1);
    check("sim_dm_rdata", dm_rdata, 0);
    check("sim_if_ready", if_ready, 0);
    mem_ack = 0; dm_req = 0; dm_we = 0;
    tick();
    check("sim_idle_req", mem_req, 0);
    tick();
    check("sim_if_addr", mem_addr, 32'h104);
    check("sim_if_we", mem_we, 0);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    check("sim_if_ready2", if_ready, 1);
    check("sim_if_rdata", if_rdata, 32'hCAFEF00D);
    mem_ack = 0; if_req = 0;
    tick();

    // Starvation: DM back-to-back, IF forced after wait saturates
    if_req = 1; if_addr = 32'h108;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    tick();
    check("stv_dm1_addr", mem_addr, 32'h300);
    mem_ack = 1; mem_rdata = 32'h11;
    tick();
    check("stv_dm1_rdata", dm_rdata, 32'h11);
    mem_ack = 0; dm_addr = 32'h304;
    tick();
    tick();
    check("stv_dm2_addr", mem_addr, 32'h304);
    mem_ack = 1; mem_rdata = 32'h22;
    tick();
    check("stv_dm2_ready", dm_ready, 1);
    mem_ack = 0; dm_addr = 32'h308;
    tick();
    check("stv_wait_sat", dut.if_wait_cnt_q, 4);
    tick();
    check("stv_if_addr", mem_addr, 32'h108);
    check("stv_wait_clr", dut.if_wait_cnt_q, 0);
    mem_ack = 1; mem_rdata = 32'h33;
    tick();
    check("stv_if_ready", if_ready, 1);
    check("stv_dm_not_ready", dm_ready, 0);
    mem_ack = 0; if_req = 0;
    tick();
    tick();
    check("stv_dm3_addr", mem_addr, 32'h308);
    mem_ack = 1; mem_rdata = 32'h44;
    tick();
    check("stv_dm3_rdata", dm_rdata, 32'h44);
    mem_ack = 0; dm_req = 0;
    tick();

    // Timeout: DM read never acknowledged
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    tick();
    check("tmo_req_up", mem_req, 1);
    repeat (63) tick();
    check("tmo_still_busy", {mem_req, err, dm_ready}, 3'b100);
    tick();
    check("tmo_req_drop", mem_req, 0);
    check("tmo_err", err, 1);
    check("tmo_dm_ready", dm_ready, 1);
    check("tmo_dm_rdata", dm_rdata, 0);
    dm_req = 0;
    tick();
    check("tmo_err_pulse", {err, dm_ready}, 0);
    mem_ack = 1; mem_rdata = 32'h99;
    tick();
    check("tmo_stray_ack", {dm_ready, if_ready, mem_req}, 0);
    mem_ack = 0;
    tick();

    // Flush during BUSY_IF
    if_req = 1; if_addr = 32'h500;
    tick();
    if_flush = 1;
    tick();
    if_flush = 0;
    check("fl_busy", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h55;
    tick();
    check("fl_ready_supp", if_ready, 0);
    check("fl_req_drop", mem_req, 0);
    mem_ack = 0; if_addr = 32'h600;
    tick();
    tick();
    check("fl_next_addr", mem_addr, 32'h600);
    mem_ack = 1; mem_rdata = 32'h66;
    tick();
    check("fl_next_ready", if_ready, 1);
    check("fl_next_rdata", if_rdata, 32'h66);
    mem_ack = 0; if_req = 0;
    tick();

    // Reset during BUSY_DM
    dm_req = 1; dm_we = 1; dm_addr = 32'h700; dm_wdata = 32'h0BADF00D; dm_be = 4'h3;
    tick();
    check("mr_busy_be", mem_be, 4'h3);
    rst = 1'b0;
    tick();
    check("mr_state", dut.state_q, IDLE);
    check("mr_mem", {mem_req, mem_we, mem_be}, 0);
    check("mr_addr", mem_addr, 0);
    check("mr_wdata", mem_wdata, 0);
    check("mr_rdata", if_rdata | dm_rdata, 0);
    check("mr_flags", {if_ready, dm_ready, err}, 0);
    rst = 1'b1; dm_req = 0; mem_ack = 1; mem_rdata = 32'h77;
    tick();
    check("mr_late_ack", {dm_ready, mem_req}, 0);
    mem_ack = 0;
    tick();
    check("mr_after", {dm_ready, if_ready, err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
